alu_operand_issue: RTL and testbench

//  Upstream stage of the execute ALU: accepts decoded instructions and resolves

---
 rtl/alu_operand_issue.sv | 141 ++++++++++++++
 tb/tb_alu_operand_issue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// Operand issue stage in front of the execute ALU.
// It resolves rs/rt from the EX and WB forwarding paths, or from the register
// file, and it picks the immediate or rt for I2. A 2-entry elastic buffer
// (head plus skid) registers the result. in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
module alu_operand_issue #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_rs_idx,
  input  logic [IDX_W-1:0] in_rt_idx,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [IDX_W-1:0] in_rd_idx,
  input  logic             fwd_ex_valid,
  input  logic [IDX_W-1:0] fwd_ex_idx,
  input  logic [WIDTH-1:0] fwd_ex_val,
  input  logic             fwd_wb_valid,
  input  logic [IDX_W-1:0] fwd_wb_idx,
  input  logic [WIDTH-1:0] fwd_wb_val,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_i1,
  output logic [WIDTH-1:0] out_i2,
  output logic [SEL_W-1:0] out_sel,
  output logic [IDX_W-1:0] out_rd_idx
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [SEL_W-1:0] sel;
    logic [IDX_W-1:0] rd;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;
  logic   accept;
  logic   transfer;

  // Forwarding priority: the zero register wins, then EX, then WB, then the register file.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [IDX_W-1:0] idx,
    input logic [WIDTH-1:0] rf_val,
    input logic             ex_valid,
    input logic [IDX_W-1:0] ex_idx,
    input logic [WIDTH-1:0] ex_val,
    input logic             wb_valid,
    input logic [IDX_W-1:0] wb_idx,
    input logic [WIDTH-1:0] wb_val
  );
    if (idx == '0)                        return '0;
    else if (ex_valid && ex_idx == idx)   return ex_val;
    else if (wb_valid && wb_idx == idx)   return wb_val;
    else                                  return rf_val;
  endfunction

  assign in_ready   = (state_q != ST_TWO);
  assign out_valid  = (state_q != ST_EMPTY);
  assign accept     = in_valid & in_ready;
  assign transfer   = out_valid & out_ready;

  assign out_i1     = head_q.i1;
  assign out_i2     = head_q.i2;
  assign out_sel    = head_q.sel;
  assign out_rd_idx = head_q.rd;

  // Build the entry for the incoming instruction, with operands frozen at accept.
  always_comb begin
    new_entry.i1  = resolve(in_rs_idx, in_rs_val, fwd_ex_valid, fwd_ex_idx, fwd_ex_val,
                            fwd_wb_valid, fwd_wb_idx, fwd_wb_val);
    new_entry.i2  = in_use_imm ? in_imm
                               : resolve(in_rt_idx, in_rt_val, fwd_ex_valid, fwd_ex_idx,
                                         fwd_ex_val, fwd_wb_valid, fwd_wb_idx, fwd_wb_val);
    new_entry.sel = in_sel;
    new_entry.rd  = in_rd_idx;
  end

  // Next state for the elastic buffer. Flush overrides any accept or transfer.
  always_comb begin
    // NOTE: defaults first so that every path assigns every signal; otherwise latches are inferred.
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && transfer) begin
          head_d  = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_TWO;
        end else if (transfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (transfer) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // State and data registers, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the two data entries are reset as well, so outputs read 0 after reset and never X.
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating in parallel on the clock edge.
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed-vector bench for alu_operand_issue. It covers reset, immediate select,
// forwarding priority, backpressure ordering, simultaneous accept/transfer, flush
// and an asynchronous mid-stream reset.
module tb_alu_operand_issue;

  localparam int WIDTH = 32;
  localparam int SEL_W = 5;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_rs_idx, in_rt_idx, in_rd_idx;
  logic [WIDTH-1:0] in_rs_val, in_rt_val, in_imm;
  logic             in_use_imm;
  logic [SEL_W-1:0] in_sel;
  logic             fwd_ex_valid, fwd_wb_valid;
  logic [IDX_W-1:0] fwd_ex_idx, fwd_wb_idx;
  logic [WIDTH-1:0] fwd_ex_val, fwd_wb_val;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_i1, out_i2;
  logic [SEL_W-1:0] out_sel;
  logic [IDX_W-1:0] out_rd_idx;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_issue #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs_idx    (in_rs_idx),
    .in_rt_idx    (in_rt_idx),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_sel       (in_sel),
    .in_rd_idx    (in_rd_idx),
    .fwd_ex_valid (fwd_ex_valid),
    .fwd_ex_idx   (fwd_ex_idx),
    .fwd_ex_val   (fwd_ex_val),
    .fwd_wb_valid (fwd_wb_valid),
    .fwd_wb_idx   (fwd_wb_idx),
    .fwd_wb_val   (fwd_wb_val),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_i1       (out_i1),
    .out_i2       (out_i2),
    .out_sel      (out_sel),
    .out_rd_idx   (out_rd_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with no forwarding and the immediate unused.
  task automatic drive(input logic [IDX_W-1:0] rs, input logic [WIDTH-1:0] rs_val,
                       input logic [IDX_W-1:0] rt, input logic [WIDTH-1:0] rt_val,
                       input logic [SEL_W-1:0] sel, input logic [IDX_W-1:0] rd);
    in_valid   = 1'b1;
    in_rs_idx  = rs;
    in_rs_val  = rs_val;
    in_rt_idx  = rt;
    in_rt_val  = rt_val;
    in_imm     = '0;
    in_use_imm = 1'b0;
    in_sel     = sel;
    in_rd_idx  = rd;
  endtask

  task automatic no_fwd();
    fwd_ex_valid = 1'b0; fwd_ex_idx = '0; fwd_ex_val = '0;
    fwd_wb_valid = 1'b0; fwd_wb_idx = '0; fwd_wb_val = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    in_valid  = 1'b0;
    no_fwd();
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_i1",    out_i1,             32'd0);
    check("rst_out_i2",    out_i2,             32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Immediate select. The rt forward must be ignored when the immediate is used.
    drive(5'd3, 32'd5, 5'd4, 32'h44, 5'd16, 5'd9);
    in_use_imm   = 1'b1;
    in_imm       = 32'h10;
    fwd_ex_valid = 1'b1; fwd_ex_idx = 5'd4; fwd_ex_val = 32'h99;
    out_ready    = 1'b1;
    step();
    check("imm_valid", {31'b0, out_valid}, 32'd1);
    check("imm_i1",    out_i1,             32'd5);
    check("imm_i2",    out_i2,             32'h10);
    check("imm_sel",   {27'b0, out_sel},   32'd16);
    check("imm_rd",    {27'b0, out_rd_idx}, 32'd9);
    in_valid = 1'b0;
    no_fwd();
    step();
    check("imm_drain", {31'b0, out_valid}, 32'd0);

    // EX has priority over WB on the same index.
    drive(5'd7, 32'h11, 5'd2, 32'h22, 5'd1, 5'd1);
    fwd_ex_valid = 1'b1; fwd_ex_idx = 5'd7; fwd_ex_val = 32'hAA;
    fwd_wb_valid = 1'b1; fwd_wb_idx = 5'd7; fwd_wb_val = 32'hBB;
    step();
    check("fwd_ex_i1", out_i1, 32'hAA);
    check("fwd_ex_i2", out_i2, 32'h22);
    // With only WB valid, the WB value is used. This is an accept and a transfer in state ONE.
    fwd_ex_valid = 1'b0;
    in_sel = 5'd2;
    step();
    check("fwd_wb_i1",     out_i1,             32'hBB);
    check("sim_one_valid", {31'b0, out_valid}, 32'd1);
    check("sim_one_ready", {31'b0, in_ready},  32'd1);
    check("sim_one_sel",   {27'b0, out_sel},   32'd2);
    // Index 0 is never forwarded, and rt=7 picks up the WB value.
    drive(5'd0, 32'h55, 5'd7, 32'h77, 5'd3, 5'd3);
    fwd_ex_valid = 1'b1; fwd_ex_idx = 5'd0; fwd_ex_val = 32'hCC;
    step();
    check("zero_i1", out_i1, 32'd0);
    check("wb_i2",   out_i2, 32'hBB);
    in_valid = 1'b0;
    no_fwd();
    step();
    check("fwd_drain", {31'b0, out_valid}, 32'd0);

    // Backpressure: A and B are stored and C stalls, then all three drain in order.
    out_ready = 1'b0;
    drive(5'd1, 32'hA, 5'd0, 0, 5'd10, 5'd1);
    step();
    check("bp_a_head", out_i1, 32'hA);
    check("bp_one_rdy", {31'b0, in_ready}, 32'd1);
    drive(5'd2, 32'hB, 5'd0, 0, 5'd11, 5'd2);
    step();
    check("bp_two_rdy", {31'b0, in_ready}, 32'd0);
    check("bp_hold_a",  out_i1,            32'hA);
    drive(5'd3, 32'hC, 5'd0, 0, 5'd12, 5'd3);
    step();
    check("bp_stall_a",  out_i1,            32'hA);
    check("bp_stall_sel", {27'b0, out_sel}, 32'd10);
    out_ready = 1'b1;
    step();
    check("bp_b_head", out_i1,             32'hB);
    check("bp_b_rdy",  {31'b0, in_ready},  32'd1);
    step();
    check("bp_c_head", out_i1,             32'hC);
    check("bp_c_rd",   {27'b0, out_rd_idx}, 32'd3);
    in_valid = 1'b0;
    step();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush in state TWO, together with an accept attempt and out_ready.
    out_ready = 1'b0;
    drive(5'd4, 32'hD, 5'd0, 0, 5'd4, 5'd4);
    step();
    drive(5'd5, 32'hE, 5'd0, 0, 5'd5, 5'd5);
    step();
    check("fl_two_rdy", {31'b0, in_ready}, 32'd0);
    drive(5'd6, 32'hF, 5'd0, 0, 5'd6, 5'd6);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_ready", {31'b0, in_ready},  32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl_stay_empty", {31'b0, out_valid}, 32'd0);
    drive(5'd8, 32'h6A, 5'd0, 0, 5'd8, 5'd8);
    step();
    check("fl_next_i1", out_i1, 32'h6A);
    in_valid = 1'b0;
    step();

    // Asynchronous reset while two entries are held.
    out_ready = 1'b0;
    drive(5'd9, 32'h1234, 5'd10, 32'h5678, 5'd7, 5'd7);
    step();
    drive(5'd11, 32'h4321, 5'd12, 32'h8765, 5'd8, 5'd8);
    step();
    in_valid = 1'b0;
    check("ar_two_rdy", {31'b0, in_ready}, 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid},  32'd0);
    check("ar_ready", {31'b0, in_ready},   32'd1);
    check("ar_i1",    out_i1,              32'd0);
    check("ar_i2",    out_i2,              32'd0);
    check("ar_sel",   {27'b0, out_sel},    32'd0);
    check("ar_rd",    {27'b0, out_rd_idx}, 32'd0);
    #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_post_empty", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
